// File: rtl/arrow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arrow_pkg
// Brief    : Arrow/harpoon shared types, coordinate width and default sprite
//            geometry shared with the square-object and bitmap instances.
// Revision : 1.0 - initial release
// ============================================================================
package arrow_pkg;

    localparam int COORD_W = 11;

    localparam int DEF_ARROW_WIDTH  = 32;
    localparam int DEF_ARROW_HEIGHT = 24;
    localparam int DEF_LAUNCH_Y     = 416;
    localparam int DEF_CEILING_Y    = 32;
    localparam int DEF_ARROW_SPEED  = 4;
    localparam int DEF_STICK_FRAMES = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        STUCK  = 2'd2,
        DONE   = 2'd3
    } arrow_state_t;

endpackage
`default_nettype wire

// File: rtl/rising_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : rising_edge_detect
// Brief    : Registered rising-edge detector for synchronous key levels; the
//            pulse is one clock wide and appears one cycle after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module rising_edge_detect (
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= in;
            r_pulse <= in & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/arrow_shot_controller.sv
`default_nettype none
// ============================================================================
// Module   : arrow_shot_controller
// Brief    : Arrow sprite sequencer: launch on fire edge, climb per frame,
//            stop at the ceiling, retire on ball hit. Optional ceiling hold
//            enabled by defining ARROW_STICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_shot_controller
    import arrow_pkg::*;
#(
    parameter int ARROW_WIDTH  = DEF_ARROW_WIDTH,
    parameter int ARROW_HEIGHT = DEF_ARROW_HEIGHT,
    parameter int LAUNCH_Y     = DEF_LAUNCH_Y,
    parameter int CEILING_Y    = DEF_CEILING_Y,
    parameter int ARROW_SPEED  = DEF_ARROW_SPEED,
    parameter int STICK_FRAMES = DEF_STICK_FRAMES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               fireKey,
    input  logic [COORD_W-1:0] playerX,
    input  logic               collisionBall,
    output logic [COORD_W-1:0] topLeftX,
    output logic [COORD_W-1:0] topLeftY,
    output logic               arrowActive,
    output logic               arrowHit
);

    localparam logic [COORD_W-1:0] c_half_w     = COORD_W'(ARROW_WIDTH / 2);
    localparam logic [COORD_W-1:0] c_launch_y   = COORD_W'(LAUNCH_Y);
    localparam logic [COORD_W-1:0] c_ceiling_y  = COORD_W'(CEILING_Y);
    localparam logic [COORD_W-1:0] c_speed      = COORD_W'(ARROW_SPEED);
    localparam logic [COORD_W-1:0] c_step_floor = COORD_W'(CEILING_Y + ARROW_SPEED);

    logic               w_fire;
    arrow_state_t       r_state, w_state_nxt;
    logic [COORD_W-1:0] r_x, w_x_nxt;
    logic [COORD_W-1:0] r_y, w_y_nxt;
    logic               r_active, w_active_nxt;
    logic               r_hit, w_hit_nxt;

`ifdef ARROW_STICK_EN
    localparam int c_cnt_w = (STICK_FRAMES > 1) ? $clog2(STICK_FRAMES) : 1;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
`endif

    rising_edge_detect u_fire_edge (
        .clk    (clk),
        .resetN (resetN),
        .in     (fireKey),
        .pulse  (w_fire)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= c_launch_y;
            r_active <= 1'b0;
            r_hit    <= 1'b0;
`ifdef ARROW_STICK_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_active <= w_active_nxt;
            r_hit    <= w_hit_nxt;
`ifdef ARROW_STICK_EN
            r_cnt    <= w_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hit_nxt   = 1'b0;
`ifdef ARROW_STICK_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_state_nxt = FLYING;
                    w_y_nxt     = c_launch_y;
                    w_x_nxt     = (playerX >= c_half_w) ? (playerX - c_half_w) : '0;
                end
            end
            FLYING: begin
                // Collision takes priority over a coincident frame move.
                if (collisionBall) begin
                    w_hit_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_y_nxt     = c_launch_y;
                end else if (startOfFrame) begin
                    if (r_y >= c_step_floor) begin
                        w_y_nxt = r_y - c_speed;
                    end else begin
                        w_y_nxt = c_ceiling_y;
`ifdef ARROW_STICK_EN
                        w_state_nxt = STUCK;
                        w_cnt_nxt   = c_cnt_w'(STICK_FRAMES - 1);
`else
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef ARROW_STICK_EN
            STUCK: begin
                if (collisionBall) begin
                    w_hit_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_y_nxt     = c_launch_y;
                end else if (startOfFrame) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_active_nxt = (w_state_nxt == FLYING) || (w_state_nxt == STUCK);
    end

    assign topLeftX    = r_x;
    assign topLeftY    = r_y;
    assign arrowActive = r_active;
    assign arrowHit    = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_arrow_shot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arrow_shot_controller
// Brief    : Self-checking bench for arrow_shot_controller (vector table,
//            directed corner sequences, random stimulus vs reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arrow_shot_controller;

    localparam int c_width   = 32;
    localparam int c_height  = 24;
    localparam int c_launch  = 416;
    localparam int c_ceil    = 32;
    localparam int c_speed   = 4;
    localparam int c_stick   = 30;
    // Frame on which the arrow reaches the ceiling, and frame on which it retires.
    localparam int c_n_climb = (c_launch - c_ceil) / c_speed + 1;
`ifdef ARROW_STICK_EN
    localparam int c_n_total = c_n_climb + c_stick;
`else
    localparam int c_n_total = c_n_climb;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        fireKey;
    logic [10:0] playerX;
    logic        collisionBall;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        arrowActive;
    logic        arrowHit;

    int errors = 0;
    int checks = 0;

    // Reference model: flight described by frame count since launch.
    bit m_prev, m_pulse, m_fly, m_done, m_hit;
    int m_f, m_x, m_y;

    arrow_shot_controller #(
        .ARROW_WIDTH  (c_width),
        .ARROW_HEIGHT (c_height),
        .LAUNCH_Y     (c_launch),
        .CEILING_Y    (c_ceil),
        .ARROW_SPEED  (c_speed),
        .STICK_FRAMES (c_stick)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .fireKey       (fireKey),
        .playerX       (playerX),
        .collisionBall (collisionBall),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .arrowActive   (arrowActive),
        .arrowHit      (arrowHit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_pulse = 0; m_fly = 0; m_done = 0; m_hit = 0;
        m_f = 0; m_x = 0; m_y = c_launch;
    endtask

    task automatic step(input bit f, input int px, input bit s, input bit c);
        fireKey       = f;
        playerX       = px[10:0];
        startOfFrame  = s;
        collisionBall = c;
        @(posedge clk);
        m_hit = 0;
        if (m_done) begin
            m_done = 0;
        end else if (!m_fly) begin
            if (m_pulse) begin
                m_fly = 1;
                m_f   = 0;
                m_y   = c_launch;
                m_x   = (px >= c_width / 2) ? px - c_width / 2 : 0;
            end
        end else if (c) begin
            m_hit = 1;
            m_fly = 0;
            m_y   = c_launch;
        end else if (s) begin
            m_f++;
            m_y = (m_f < c_n_climb) ? c_launch - c_speed * m_f : c_ceil;
            if (m_f >= c_n_total) begin
                m_fly  = 0;
                m_done = 1;
            end
        end
        m_pulse = f & ~m_prev;
        m_prev  = f;
        #1;
        chk("model_active", int'(arrowActive), int'(m_fly));
        chk("model_hit",    int'(arrowHit),    int'(m_hit));
        chk("model_x",      int'(topLeftX),    m_x);
        chk("model_y",      int'(topLeftY),    m_y);
    endtask

    typedef struct {
        bit fire; int px; bit sof; bit col;
        bit e_act; int e_x; int e_y; bit e_hit;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int frames;
        bit rf;

        tbl[0] = '{1, 320, 0, 0, 0,   0, 416, 0};
        tbl[1] = '{1, 320, 0, 0, 1, 304, 416, 0};
        tbl[2] = '{0, 320, 1, 0, 1, 304, 412, 0};
        tbl[3] = '{0, 320, 1, 0, 1, 304, 408, 0};
        tbl[4] = '{0, 320, 1, 0, 1, 304, 404, 0};
        tbl[5] = '{1, 100, 0, 0, 1, 304, 404, 0};
        tbl[6] = '{0, 100, 0, 0, 1, 304, 404, 0};
        tbl[7] = '{0, 100, 0, 0, 1, 304, 404, 0};

        resetN = 1'b0; fireKey = 0; startOfFrame = 0; collisionBall = 0; playerX = '0;
        model_reset();
        #22;
        chk("rst_active", int'(arrowActive), 0);
        chk("rst_hit",    int'(arrowHit),    0);
        chk("rst_x",      int'(topLeftX),    0);
        chk("rst_y",      int'(topLeftY),    c_launch);
        resetN = 1'b1;

        // Launch, first frames, frozen X, ignored fire edge.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].fire, tbl[i].px, tbl[i].sof, tbl[i].col);
            chk($sformatf("vec%0d_active", i), int'(arrowActive), int'(tbl[i].e_act));
            chk($sformatf("vec%0d_x", i),      int'(topLeftX),    tbl[i].e_x);
            chk($sformatf("vec%0d_y", i),      int'(topLeftY),    tbl[i].e_y);
            chk($sformatf("vec%0d_hit", i),    int'(arrowHit),    int'(tbl[i].e_hit));
        end

        // Climb to 200 and hit with a coincident frame pulse.
        for (int i = 0; i < 51; i++) step(0, 100, 1, 0);
        chk("pre_hit_y", int'(topLeftY), 200);
        step(0, 100, 1, 1);
        chk("hit_pulse",  int'(arrowHit),    1);
        chk("hit_active", int'(arrowActive), 0);
        chk("hit_y",      int'(topLeftY),    c_launch);
        step(0, 100, 0, 0);
        chk("hit_one_cycle", int'(arrowHit), 0);

        // Full flight with fire held throughout and afterwards.
        step(1, 320, 0, 0);
        step(1, 320, 0, 0);
        chk("launch2_active", int'(arrowActive), 1);
        frames = 0;
        while (arrowActive && frames < 300) begin
            step(1, 320, 1, 0);
            frames++;
            chk("flight_no_hit", int'(arrowHit), 0);
            if (frames == c_n_climb - 1) chk("ceiling_reach_y", int'(topLeftY), c_ceil);
        end
        chk("flight_frames", frames, c_n_total);
        for (int i = 0; i < 10; i++) step(1, 320, 1, 0);
        chk("held_no_relaunch", int'(arrowActive), 0);

        // Re-arm by releasing fire; launch at left edge saturates X.
        step(0, 5, 0, 0);
        step(1, 5, 0, 0);
        step(1, 5, 0, 0);
        chk("sat_active", int'(arrowActive), 1);
        chk("sat_x",      int'(topLeftX),    0);
        step(0, 5, 1, 0);
        step(0, 5, 1, 0);

        // Asynchronous reset mid-flight.
        fireKey = 0; startOfFrame = 0; collisionBall = 0;
        #2;
        resetN = 1'b0;
        #1;
        chk("midrst_active", int'(arrowActive), 0);
        chk("midrst_hit",    int'(arrowHit),    0);
        chk("midrst_x",      int'(topLeftX),    0);
        chk("midrst_y",      int'(topLeftY),    c_launch);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // Random stimulus against the model.
        rf = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) rf = ~rf;
            step(rf, int'($urandom_range(0, 700)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
